// File: rtl/branch_predictor_if.sv
// Fetch-lookup / ID-update / statistics bundle for the dynamic branch predictor.
// The predictor takes the slave view; the pipeline (or a bench) takes the master view.
interface branch_predictor_if #(
    parameter int XLEN  = 32,
    parameter int GHR_W = 6
);
    logic [XLEN-1:0]  pc_i;
    logic             pred_taken_o;
    logic [XLEN-1:0]  pred_target_o;
    logic [GHR_W-1:0] pred_ghr_o;
    logic             upd_valid_i;
    logic [XLEN-1:0]  upd_pc_i;
    logic             upd_taken_i;
    logic [XLEN-1:0]  upd_target_i;
    logic [GHR_W-1:0] upd_ghr_i;
    logic             upd_mispred_i;
    logic [31:0]      stat_branch_o;
    logic [31:0]      stat_mispred_o;

    modport slave (
        input  pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i, upd_ghr_i, upd_mispred_i,
        output pred_taken_o, pred_target_o, pred_ghr_o, stat_branch_o, stat_mispred_o
    );

    modport master (
        output pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i, upd_ghr_i, upd_mispred_i,
        input  pred_taken_o, pred_target_o, pred_ghr_o, stat_branch_o, stat_mispred_o
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped dynamic branch predictor (2-bit counters, tag, target) with branch/mispredict stats.
// Define BP_GSHARE_EN to XOR a global history register into the table index.
module branch_predictor #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 8,
    parameter int GHR_W   = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    branch_predictor_if.slave bp
);
    localparam int IDX_W = $clog2(ENTRIES);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
    } entry_t;

    logic [ENTRIES-1:0]      valid_q;
    logic [ENTRIES-1:0][1:0] ctr_q;
    entry_t                  pay_q [ENTRIES];

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             lk_hit, up_hit;
    logic [1:0]       ctr_d;
    logic [31:0]      stat_branch_q, stat_branch_d;
    logic [31:0]      stat_mispred_q, stat_mispred_d;
    logic             unused_ok;

    assign lk_tag = bp.pc_i[IDX_W+TAG_W+1:IDX_W+2];
    assign up_tag = bp.upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];

`ifdef BP_GSHARE_EN
    logic [GHR_W-1:0] ghr_q, ghr_d;

    assign lk_idx        = bp.pc_i[IDX_W+1:2] ^ IDX_W'(ghr_q);
    assign up_idx        = bp.upd_pc_i[IDX_W+1:2] ^ IDX_W'(bp.upd_ghr_i);
    assign ghr_d         = bp.upd_valid_i ? {ghr_q[GHR_W-2:0], bp.upd_taken_i} : ghr_q;
    assign bp.pred_ghr_o = ghr_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) ghr_q <= '0;
        else        ghr_q <= ghr_d;
    end
`else
    assign lk_idx        = bp.pc_i[IDX_W+1:2];
    assign up_idx        = bp.upd_pc_i[IDX_W+1:2];
    assign bp.pred_ghr_o = {GHR_W{1'b0}};
`endif

    // Only a slice of each PC forms index/tag; history input is unused without gshare.
    assign unused_ok = ^{bp.pc_i, bp.upd_pc_i, bp.upd_ghr_i};

    // Lookup reads registered state only, so a same-cycle update is not bypassed.
    assign lk_hit           = valid_q[lk_idx] && (pay_q[lk_idx].tag == lk_tag);
    assign bp.pred_taken_o  = lk_hit && ctr_q[lk_idx][1];
    assign bp.pred_target_o = bp.pred_taken_o ? pay_q[lk_idx].target : bp.pc_i + XLEN'(4);

    assign up_hit = valid_q[up_idx] && (pay_q[up_idx].tag == up_tag);

    always_comb begin
        ctr_d = ctr_q[up_idx];
        if (!up_hit)                ctr_d = 2'b10;
        else if (bp.upd_taken_i)    ctr_d = (ctr_d == 2'b11) ? 2'b11 : ctr_d + 2'b01;
        else                        ctr_d = (ctr_d == 2'b00) ? 2'b00 : ctr_d - 2'b01;
    end

    // A not-taken miss leaves the table untouched.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            ctr_q   <= {ENTRIES{2'b01}};
        end else if (bp.upd_valid_i && (up_hit || bp.upd_taken_i)) begin
            valid_q[up_idx] <= 1'b1;
            ctr_q[up_idx]   <= ctr_d;
        end
    end

    // Payload is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (bp.upd_valid_i && bp.upd_taken_i)
            pay_q[up_idx] <= '{tag: up_tag, target: bp.upd_target_i};
    end

    always_comb begin
        stat_branch_d  = stat_branch_q;
        stat_mispred_d = stat_mispred_q;
        if (bp.upd_valid_i) begin
            stat_branch_d = stat_branch_q + 32'd1;
            if (bp.upd_mispred_i) stat_mispred_d = stat_mispred_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stat_branch_q  <= '0;
            stat_mispred_q <= '0;
        end else begin
            stat_branch_q  <= stat_branch_d;
            stat_mispred_q <= stat_mispred_d;
        end
    end

    assign bp.stat_branch_o  = stat_branch_q;
    assign bp.stat_mispred_o = stat_mispred_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboarded random/directed bench for branch_predictor against a table-level reference model.
module tb_branch_predictor;
    localparam int XLEN    = 32;
    localparam int ENTRIES = 64;
    localparam int TAG_W   = 8;
    localparam int GHR_W   = 6;
    localparam int IDX_W   = $clog2(ENTRIES);
`ifdef BP_GSHARE_EN
    localparam bit GS = 1'b1;
`else
    localparam bit GS = 1'b0;
`endif

    typedef struct packed {
        bit             tk;
        bit [31:0]      tgt;
        bit [GHR_W-1:0] ghr;
        bit [31:0]      sb;
        bit [31:0]      sm;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    branch_predictor_if #(.XLEN(XLEN), .GHR_W(GHR_W)) bp();

    branch_predictor #(.XLEN(XLEN), .ENTRIES(ENTRIES), .TAG_W(TAG_W), .GHR_W(GHR_W)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bp    (bp)
    );

    always #5 clk = ~clk;

    // Reference model: one record per table slot, counter kept as a 0..3 integer.
    bit             m_v   [ENTRIES];
    bit [TAG_W-1:0] m_tag [ENTRIES];
    bit [31:0]      m_tgt [ENTRIES];
    int             m_ctr [ENTRIES];
    bit [31:0]      m_sb, m_sm;
    int unsigned    m_ghr;

    function automatic int m_idx(bit [31:0] pc, int unsigned g);
        return int'(((pc >> 2) % ENTRIES) ^ g);
    endfunction

    function automatic bit [TAG_W-1:0] m_tagf(bit [31:0] pc);
        return TAG_W'((pc >> (2 + IDX_W)) % (1 << TAG_W));
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_v[i]   = 1'b0;
            m_ctr[i] = 1;
        end
        m_sb  = 0;
        m_sm  = 0;
        m_ghr = 0;
    endfunction

    function automatic exp_t m_predict(bit [31:0] pc);
        exp_t e;
        int   i   = m_idx(pc, GS ? m_ghr : 0);
        bit   hit = m_v[i] && (m_tag[i] == m_tagf(pc));
        e.tk  = hit && (m_ctr[i] >= 2);
        e.tgt = e.tk ? m_tgt[i] : pc + 32'd4;
        e.ghr = GS ? GHR_W'(m_ghr) : '0;
        e.sb  = m_sb;
        e.sm  = m_sm;
        return e;
    endfunction

    function automatic void m_update(bit [31:0] upc, bit ut, bit [31:0] utgt,
                                     bit [GHR_W-1:0] ughr, bit um);
        int i   = m_idx(upc, GS ? int'(ughr) : 0);
        bit hit = m_v[i] && (m_tag[i] == m_tagf(upc));
        if (hit) begin
            if (ut) begin
                m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                m_tgt[i] = utgt;
            end else begin
                m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
            end
        end else if (ut) begin
            m_v[i]   = 1'b1;
            m_tag[i] = m_tagf(upc);
            m_tgt[i] = utgt;
            m_ctr[i] = 2;
        end
        m_sb = m_sb + 1;
        if (um) m_sm = m_sm + 1;
        if (GS) m_ghr = ((m_ghr << 1) | int'(ut)) % (1 << GHR_W);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: the lookup port answers every cycle, so one expectation is retired per cycle.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("pred_taken",   32'(bp.pred_taken_o),   32'(e.tk));
            chk("pred_target",  bp.pred_target_o,       e.tgt);
            chk("pred_ghr",     32'(bp.pred_ghr_o),     32'(e.ghr));
            chk("stat_branch",  bp.stat_branch_o,       e.sb);
            chk("stat_mispred", bp.stat_mispred_o,      e.sm);
        end
    end

    // One fetch cycle: drive, optionally assert reset between edges, push expectation, advance model.
    task automatic cyc(input bit [31:0] pc, input bit uv, input bit [31:0] upc, input bit ut,
                       input bit [31:0] utgt, input bit [GHR_W-1:0] ughr, input bit um,
                       input bit rlvl, input bit rmid);
        @(posedge clk);
        #1;
        rst_n            = rlvl;
        bp.pc_i          = pc;
        bp.upd_valid_i   = uv;
        bp.upd_pc_i      = upc;
        bp.upd_taken_i   = ut;
        bp.upd_target_i  = utgt;
        bp.upd_ghr_i     = ughr;
        bp.upd_mispred_i = um;
        if (!rlvl) m_reset();
        if (rmid) begin
            #2;
            rst_n = 1'b0;
            m_reset();
        end
        q.push_back(m_predict(pc));
        if (rst_n && uv) m_update(upc, ut, utgt, ughr, um);
    endtask

    task automatic look(input bit [31:0] pc);
        cyc(pc, 1'b0, 32'h0, 1'b0, 32'h0, '0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic upd(input bit [31:0] pc, input bit [31:0] upc, input bit ut,
                       input bit [31:0] utgt, input bit um);
        cyc(pc, 1'b1, upc, ut, utgt, GHR_W'(m_ghr), um, 1'b1, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit [31:0] pool [16];
        bit [31:0] pc, upc;

        bp.pc_i = '0; bp.upd_valid_i = 1'b0; bp.upd_pc_i = '0; bp.upd_taken_i = 1'b0;
        bp.upd_target_i = '0; bp.upd_ghr_i = '0; bp.upd_mispred_i = 1'b0;
        m_reset();

        // Reset state, including an update attempted while held in reset.
        cyc(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, '0, 1'b0, 1'b0, 1'b0);
        cyc(32'h100, 1'b1, 32'h100, 1'b1, 32'h80, '0, 1'b1, 1'b0, 1'b0);

        // Allocate, then hysteresis around the saturated counter.
        upd(32'h100, 32'h100, 1'b1, 32'h80, 1'b1);
        look(32'h100);
        repeat (3) upd(32'h100, 32'h100, 1'b1, 32'h80, 1'b0);
        upd(32'h100, 32'h100, 1'b0, 32'h0, 1'b1);
        look(32'h100);
        repeat (2) upd(32'h100, 32'h100, 1'b0, 32'h0, 1'b0);
        look(32'h100);
        look(32'h200);

        // Same-cycle lookup and update: old contents visible until the next cycle.
        upd(32'h100, 32'h100, 1'b1, 32'h80, 1'b0);
        upd(32'h100, 32'h100, 1'b1, 32'h80, 1'b1);
        look(32'h100);

        // Asynchronous reset between edges, with an update in flight.
        cyc(32'h100, 1'b1, 32'h100, 1'b1, 32'h80, '0, 1'b1, 1'b1, 1'b1);
        look(32'h100);

        // History pattern T,T,N.
        upd(32'h100, 32'h140, 1'b1, 32'h40, 1'b0);
        upd(32'h100, 32'h140, 1'b1, 32'h40, 1'b0);
        upd(32'h100, 32'h140, 1'b0, 32'h0, 1'b0);
        look(32'h100);

        // Random traffic over a small PC pool so hits, aliases and wraps all occur.
        for (int k = 0; k < 14; k++)
            pool[k] = (32'($urandom_range(0, 2)) << (IDX_W + 2)) | (32'($urandom_range(0, 7)) << 2);
        pool[14] = 32'h8000_0100;
        pool[15] = 32'hFFFF_FFFC;

        for (int n = 0; n < 3000; n++) begin
            pc  = pool[$urandom_range(0, 15)];
            upc = pool[$urandom_range(0, 15)];
            if ($urandom_range(0, 299) == 0)
                cyc(pc, 1'b1, upc, 1'b1, $urandom() & 32'hFFFF_FFFC, '0, 1'b0, 1'b1, 1'b1);
            else
                cyc(pc, 1'($urandom_range(0, 1)), upc, 1'($urandom_range(0, 1)),
                    $urandom() & 32'hFFFF_FFFC,
                    ($urandom_range(0, 1) == 1) ? GHR_W'(m_ghr) : GHR_W'($urandom()),
                    1'($urandom_range(0, 1)), 1'b1, 1'b0);
        end

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
